floating_point_divider: RTL and testbench

//  Iterative IEEE-754 single-precision divider, result = a / b; the inverse companion of floating_point_multiplier.

---
 rtl/fp32_pkg.sv | 36 +++
 rtl/fp_div_iter.sv | 24 ++
 rtl/floating_point_divider.sv | 162 ++++++++++++++++
 tb/tb_floating_point_divider.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared definitions for the single-precision divider: field widths, bias, FSM
// state encodings, operand classes and field-slice helpers.
package fp32_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 254;
  // Quotient/remainder datapath width: hidden bit plus one guard bit.
  localparam int unsigned Q_W     = MANT_W + 2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_NORM = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Operand class, fixed at capture time.
  typedef logic [1:0] cls_t;
  localparam cls_t CLS_NORM = 2'd0;
  localparam cls_t CLS_ZERO = 2'd1;
  localparam cls_t CLS_DIVZ = 2'd2;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MANT_W-1:0] f_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp_div_iter.sv
// One restoring-division step.
//   r      : current partial remainder (25 bits, always < 2*d)
//   d      : divisor mantissa with hidden bit (24 bits)
//   r_next : remainder after optional subtract and left shift
//   qbit   : quotient bit produced by this step
module fp_div_iter
  import fp32_pkg::*;
(
  input  logic [Q_W-1:0]  r,
  input  logic [Q_W-2:0]  d,
  output logic [Q_W-1:0]  r_next,
  output logic            qbit
);

  logic [Q_W-1:0] rem;

  always_comb begin
    qbit   = (r >= {1'b0, d});
    rem    = qbit ? (r - {1'b0, d}) : r;
    // rem < d < 2^24, so the dropped MSB is always zero.
    r_next = {rem[Q_W-2:0], 1'b0};
  end

endmodule

// File: rtl/floating_point_divider.sv
// Iterative IEEE-754 single-precision divider, result = a / b.
// One quotient bit per clock; fixed latency of 27 edges from accepted start to done.
// Truncating, zero-exponent operands read as zero, overflow keeps the wrapped exponent.
//   clk, rst_n : clock and synchronous active-low reset
//   start      : request, sampled only while idle
//   a, b       : dividend / divisor, captured on accepted start
//   busy       : high while computing (CALC and NORM)
//   done       : one-cycle pulse when result/overflow update
//   result     : quotient, held until the next completed operation
//   overflow   : exponent out of range or divide-by-zero, held with result
module floating_point_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow
);

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [Q_W-1:0]   r_q, r_d;
  logic [Q_W-2:0]   d_q, d_d;
  logic [Q_W-1:0]   q_q, q_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
  cls_t             cls_q, cls_d;
  logic [31:0]      res_n_q, res_n_d;
  logic             ovf_n_q, ovf_n_d;
  logic [31:0]      result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [Q_W-1:0]   r_next;
  logic             qbit;
  logic [9:0]       e_norm;
  logic [MANT_W-1:0] frac_norm;
  logic             e_oor;

  fp_div_iter u_iter (
    .r      (r_q),
    .d      (d_q),
    .r_next (r_next),
    .qbit   (qbit)
  );

  // Normalisation: quotient lies in [2^23, 2^25); a missing top bit costs one exponent step.
  always_comb begin
    e_norm    = {2'b00, ea_q} - {2'b00, eb_q} + 10'(BIAS) - {9'd0, ~q_q[Q_W-1]};
    frac_norm = q_q[Q_W-1] ? q_q[MANT_W:1] : q_q[MANT_W-1:0];
    e_oor     = ($signed(e_norm) > $signed(10'(EXP_MAX))) || ($signed(e_norm) < 10'sd1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    d_d      = d_q;
    q_d      = q_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    cls_d    = cls_q;
    res_n_d  = res_n_q;
    ovf_n_d  = ovf_n_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d  = f_sign(a) ^ f_sign(b);
          ea_d    = f_exp(a);
          eb_d    = f_exp(b);
          r_d     = {2'b01, f_frac(a)};
          d_d     = {1'b1, f_frac(b)};
          q_d     = '0;
          cnt_d   = '0;
          if (f_exp(b) == '0)      cls_d = CLS_DIVZ;
          else if (f_exp(a) == '0) cls_d = CLS_ZERO;
          else                     cls_d = CLS_NORM;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        r_d   = r_next;
        q_d   = {q_q[Q_W-2:0], qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(Q_W - 1)) state_d = ST_NORM;
      end
      ST_NORM: begin
        case (cls_q)
          CLS_DIVZ: begin
            res_n_d = {sign_q, 8'hFF, 23'd0};
            ovf_n_d = 1'b1;
          end
          CLS_ZERO: begin
            res_n_d = {sign_q, 31'd0};
            ovf_n_d = 1'b0;
          end
          default: begin
            res_n_d = {sign_q, e_norm[EXP_W-1:0], frac_norm};
            ovf_n_d = e_oor;
          end
        endcase
        state_d = ST_DONE;
      end
      ST_DONE: begin
        result_d = res_n_q;
        ovf_d    = ovf_n_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      d_q      <= '0;
      q_q      <= '0;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      cls_q    <= CLS_NORM;
      res_n_q  <= '0;
      ovf_n_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      d_q      <= d_d;
      q_q      <= q_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      cls_q    <= cls_d;
      res_n_q  <= res_n_d;
      ovf_n_q  <= ovf_n_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q == ST_CALC) || (state_q == ST_NORM);
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_floating_point_divider.sv
// Self-checking bench for floating_point_divider against an integer-arithmetic model.
module tb_floating_point_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, overflow;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  floating_point_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: returns {overflow, result} from the arithmetic definition of a / b.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          ea, eb, e;
    longint      ma, mb, q;
    logic [22:0] frac;
    logic [7:0]  ebits;
    s  = x[31] ^ y[31];
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    if (eb == 0) return {1'b1, s, 8'hFF, 23'd0};
    if (ea == 0) return {1'b0, s, 31'd0};
    ma = longint'({1'b1, x[22:0]});
    mb = longint'({1'b1, y[22:0]});
    q  = (ma << 24) / mb;
    e  = ea - eb + 127;
    if (q >= (64'sd1 <<< 24)) begin
      frac = q[23:1];
    end else begin
      frac = q[22:0];
      e    = e - 1;
    end
    ebits = e[7:0];
    return {(e > 254) || (e < 1), s, ebits, frac};
  endfunction

  // Launch one operation and wait (bounded) for done; cyc = edges from accepting edge.
  task automatic do_op(input logic [31:0] aa, input logic [31:0] bb,
                       output logic [31:0] r, output logic o, output int cyc);
    @(negedge clk);
    a = aa;
    b = bb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    r = result;
    o = overflow;
  endtask

  task automatic check_op(input string name, input logic [31:0] aa, input logic [31:0] bb);
    logic [31:0] r;
    logic        o;
    int          cyc;
    logic [32:0] exp_v;
    exp_v = model(aa, bb);
    do_op(aa, bb, r, o, cyc);
    n_tests++;
    if (cyc !== 27) begin
      n_fail++;
      $display("FAIL %s latency a=%h b=%h: got %0d cycles, want 27", name, aa, bb, cyc);
    end
    n_tests++;
    if (r !== exp_v[31:0] || o !== exp_v[32]) begin
      n_fail++;
      $display("FAIL %s a=%h b=%h: got %h ovf %b, want %h ovf %b",
               name, aa, bb, r, o, exp_v[31:0], exp_v[32]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, overflow, result} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset: got busy %b done %b ovf %b result %h, want all 0",
               busy, done, overflow, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [32:0] exp_v;
    // Spot-check the model against hand-derived answers, then the DUT against the model.
    exp_v = model(32'hc1950d08, 32'hc08a2000);
    n_tests++;
    if (exp_v !== {1'b0, 32'h408a2000}) begin
      n_fail++;
      $display("FAIL model_sanity: got %h, want 0408a2000", exp_v);
    end
    check_op("unity",    32'h3f800000, 32'h3f800000);
    check_op("neg_neg",  32'hc1950d08, 32'hc08a2000);
    check_op("six_two",  32'h40c00000, 32'h40000000);
    check_op("zero_num", 32'h00000000, 32'h418aa000);
    check_op("div_zero", 32'hbf800000, 32'h00000000);
    check_op("exp_hi",   32'h7f000000, 32'h00800000);
    check_op("exp_lo",   32'h00800000, 32'h7f000000);
    check_op("zero_zero", 32'h80000000, 32'h00000000);
    check_op("exp255",   32'h7f800001, 32'h3f800000);
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      // Steer some operands toward the zero/extreme exponent classes.
      if (i % 8 == 1) ra[30:23] = 8'd0;
      if (i % 8 == 3) rb[30:23] = 8'd0;
      if (i % 8 == 5) ra[30:23] = 8'(254 - $urandom_range(0, 3));
      if (i % 8 == 7) rb[30:23] = 8'($urandom_range(1, 4));
      check_op("random", ra, rb);
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] xa, xb;
    logic [32:0] exp_v;
    int          cyc;
    xa = 32'h40490fdb;
    xb = 32'h3fb504f3;
    exp_v = model(xa, xb);
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      // Extra start pulses sampled mid-CALC (edge 10) and while in DONE (edge 27).
      if (cyc == 9 || cyc == 26) begin
        start = 1'b1;
        a = $urandom;
        b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    n_tests++;
    if (cyc !== 27 || result !== exp_v[31:0] || overflow !== exp_v[32]) begin
      n_fail++;
      $display("FAIL ignore_start: got %h ovf %b after %0d, want %h ovf %b after 27",
               result, overflow, cyc, exp_v[31:0], exp_v[32]);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_busy: got busy %b during done, want 0", busy);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_idle: got busy %b done %b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic        o;
    int          cyc;
    logic [32:0] exp_v;
    do_op(32'h42c80000, 32'h41200000, r, o, cyc);
    n_tests++;
    if (r !== 32'h41200000 || cyc !== 27) begin
      n_fail++;
      $display("FAIL b2b_first: got %h after %0d, want 41200000 after 27", r, cyc);
    end
    // Still inside the done cycle: the next start is sampled at the following edge.
    a = 32'hc2f60000;
    b = 32'h40e00000;
    exp_v = model(a, b);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy %b done %b, want 1 0", busy, done);
    end
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    n_tests++;
    if (cyc !== 27 || result !== exp_v[31:0] || overflow !== exp_v[32]) begin
      n_fail++;
      $display("FAIL b2b_second: got %h ovf %b after %0d, want %h ovf %b after 27",
               result, overflow, cyc, exp_v[31:0], exp_v[32]);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    // Preload a nonzero overflowed result so the reset clear is observable.
    check_op("pre_reset", 32'h7f000000, 32'h00800000);
    @(negedge clk);
    a = 32'h40400000;
    b = 32'h3f800000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, overflow, result} !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy %b done %b ovf %b result %h, want all 0",
               busy, done, overflow, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done || busy) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_abort: got %0d active cycles after reset, want 0", seen);
    end
    check_op("post_reset", 32'h40400000, 32'h3f800000);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
